// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;
   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      RUN,
      FIX
   } muldiv_state_t;
endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side request and HI/LO result bundle for the mul/div unit.
interface ex_muldiv_unit_if #(parameter int XLEN = muldiv_pkg::XLEN);
   import muldiv_pkg::*;

   logic            start;
   muldiv_op_t      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            hilo_read;
   logic            flush;
   logic            busy;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (
      output start, op, a, b, hilo_read, flush,
      input  busy, stall, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, hilo_read, flush,
      output busy, stall, done, hi, lo
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO; one shift-add or
// restoring shift-subtract step per cycle, sign fix-up on the way out.
module ex_muldiv_unit #(
   parameter int XLEN = muldiv_pkg::XLEN
) (
   input  logic             clk,
   input  logic             rst,
   ex_muldiv_unit_if.slave  bus
);
   import muldiv_pkg::*;

   localparam int            CW   = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   muldiv_state_t     state;
   muldiv_op_t        op_q;
   logic [XLEN-1:0]   a_q;
   logic [XLEN-1:0]   mag_b;
   logic [2*XLEN-1:0] acc;
   logic [CW-1:0]     count;
   logic              sign_q;
   logic              sign_r;
   logic              done_q;
   logic [XLEN-1:0]   hi_q;
   logic [XLEN-1:0]   lo_q;

   logic              is_div;
   logic              is_signed;
   logic              busy;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_upper;
   logic              div_ok;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   rem;

   assign is_div    = op_q[1];
   assign is_signed = ~op_q[0];
   assign busy      = (state != IDLE);
   assign mag_a     = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;

   // Multiply: acc = {partial product, remaining multiplier bits}.
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]}
                   + {1'b0, (acc[0] ? mag_b : {XLEN{1'b0}})};
   assign mul_next = {mul_sum, acc[XLEN-1:1]};

   // Divide: acc = {partial remainder, dividend bits / quotient bits}.
   // The shifted remainder needs XLEN+1 bits; after a successful subtract
   // the result is below mag_b, so the low XLEN bits of the difference suffice.
   assign div_upper = acc[2*XLEN-1:XLEN-1];
   assign div_ok    = (div_upper >= {1'b0, mag_b});
   assign div_rem   = div_upper[XLEN-1:0] - mag_b;
   assign div_next  = div_ok ? {div_rem, acc[XLEN-2:0], 1'b1}
                             : {div_upper[XLEN-1:0], acc[XLEN-2:0], 1'b0};

   assign quot = acc[XLEN-1:0];
   assign rem  = acc[2*XLEN-1:XLEN];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         op_q   <= OP_MULT;
         a_q    <= '0;
         mag_b  <= '0;
         acc    <= '0;
         count  <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         done_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     op_q  <= bus.op;
                     a_q   <= bus.a;
                     mag_b <= bus.b;
                     state <= PREP;
                  end
               end
               PREP: begin
                  // mag_b still holds raw b here, so its sign bit is b's sign.
                  sign_q <= is_signed & (a_q[XLEN-1] ^ mag_b[XLEN-1]);
                  sign_r <= is_signed & a_q[XLEN-1];
                  mag_b  <= (is_signed && mag_b[XLEN-1]) ? -mag_b : mag_b;
                  acc    <= {{XLEN{1'b0}}, mag_a};
                  count  <= '0;
                  state  <= RUN;
               end
               RUN: begin
                  acc   <= is_div ? div_next : mul_next;
                  count <= count + 1'b1;
                  if (count == LAST) state <= FIX;
               end
               FIX: begin
                  if (!is_div) begin
                     {hi_q, lo_q} <= sign_q ? -acc : acc;
                  end else if (mag_b == '0) begin
                     lo_q <= '1;
                     hi_q <= a_q;
                  end else begin
                     lo_q <= sign_q ? -quot : quot;
                     hi_q <= sign_r ? -rem : rem;
                  end
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.busy  = busy;
   assign bus.stall = busy & (bus.start | bus.hilo_read);
   assign bus.done  = done_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Random + directed bench for ex_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ex_muldiv_unit_if bus ();
   ex_muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   function automatic void model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
      longint sa, sb, p;
      logic [63:0] u;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h = '0; l = '0;
      case (op)
         OP_MULT:  begin p = sa * sb; {h, l} = p; end
         OP_MULTU: begin u = {32'b0, a} * {32'b0, b}; {h, l} = u; end
         default: begin
            if (b == 32'd0) begin
               l = '1; h = a;
            end else if (op == OP_DIV) begin
               p = sa / sb; l = p[31:0];
               p = sa % sb; h = p[31:0];
            end else begin
               l = a / b; h = a % b;
            end
         end
      endcase
   endfunction

   task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Issues one op, checks latency, done pulse, busy window and HI/LO vs model.
   task automatic run_op(input string name, input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
      int done_at, pulses, busy_bad, early_bad;
      logic [31:0] nh, nl;
      done_at = 0; pulses = 0; busy_bad = 0; early_bad = 0;
      issue(op, a, b);
      if (!bus.busy) busy_bad++;
      for (int n = 1; n <= 35; n++) begin
         @(posedge clk); #1;
         if (bus.done) begin pulses++; if (done_at == 0) done_at = n; end
         if ((n < 34) && (!bus.busy || bus.hi !== exp_hi || bus.lo !== exp_lo)) early_bad++;
         if ((n < 34) && !bus.busy) busy_bad++;
         if ((n >= 34) && bus.busy) busy_bad++;
      end
      model(op, a, b, nh, nl);
      exp_hi = nh; exp_lo = nl;
      n_tests += 5;
      if (done_at !== 34) begin n_fail++; $display("FAIL %s latency: got %0d want 34", name, done_at); end
      if (pulses !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d want 1", name, pulses); end
      if (busy_bad !== 0 || early_bad !== 0) begin
         n_fail++; $display("FAIL %s busy/early: got %0d/%0d want 0/0", name, busy_bad, early_bad);
      end
      if (bus.hi !== exp_hi) begin n_fail++; $display("FAIL %s hi: got %h want %h", name, bus.hi, exp_hi); end
      if (bus.lo !== exp_lo) begin n_fail++; $display("FAIL %s lo: got %h want %h", name, bus.lo, exp_lo); end
   endtask

   task automatic test_reset();
      bus.start = 0; bus.op = OP_MULT; bus.a = 0; bus.b = 0; bus.hilo_read = 0; bus.flush = 0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests += 4;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         n_fail++; $display("FAIL reset_hilo: got %h/%h want 0/0", bus.hi, bus.lo);
      end
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
      if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      muldiv_op_t  ops [7] = '{OP_MULTU, OP_MULT, OP_MULT, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
      logic [31:0] as  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'h1234};
      logic [31:0] bs  [7] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};
      logic [31:0] his [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'd2, 32'd0, 32'h1234};
      logic [31:0] los [7] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000, 32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFF};
      for (int i = 0; i < 7; i++) begin
         run_op($sformatf("directed%0d", i), ops[i], as[i], bs[i]);
         n_tests++;
         if (bus.hi !== his[i] || bus.lo !== los[i]) begin
            n_fail++;
            $display("FAIL directed%0d_const: got %h/%h want %h/%h", i, bus.hi, bus.lo, his[i], los[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      muldiv_op_t op;
      for (int i = 0; i < 24; i++) begin
         op = muldiv_op_t'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = $urandom_range(1, 9);
            2: a = 32'h80000000;
            3: b = 32'hFFFFFFFF;
            default: ;
         endcase
         run_op($sformatf("rand%0d", i), op, a, b);
      end
   endtask

   task automatic test_stall_ignore();
      int stall_bad, done_at;
      logic [31:0] nh, nl;
      stall_bad = 0; done_at = 0;
      bus.hilo_read = 1'b1; #1;
      n_tests++;
      if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got %b want 0", bus.stall); end
      issue(OP_MULTU, 32'hFFFFFFFF, 32'd3);
      for (int n = 1; n <= 36; n++) begin
         @(posedge clk); #1;
         if (bus.done && done_at == 0) done_at = n;
         if (n == 5) begin bus.hilo_read = 0; bus.start = 1; bus.op = OP_DIVU; bus.a = 5; bus.b = 5; #1; end
         if (n == 6) begin bus.hilo_read = 1; bus.start = 0; #1; end
         if (bus.stall !== (n < 34)) stall_bad++;
      end
      bus.hilo_read = 1'b0;
      model(OP_MULTU, 32'hFFFFFFFF, 32'd3, nh, nl);
      exp_hi = nh; exp_lo = nl;
      n_tests += 4;
      if (stall_bad !== 0) begin n_fail++; $display("FAIL stall_window: got %0d bad cycles want 0", stall_bad); end
      if (done_at !== 34) begin n_fail++; $display("FAIL ignore_latency: got %0d want 34", done_at); end
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_restart: got busy %b want 0", bus.busy); end
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
         n_fail++; $display("FAIL ignore_result: got %h/%h want %h/%h", bus.hi, bus.lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_flush();
      int dones, busy_at12;
      dones = 0; busy_at12 = 1;
      issue(OP_DIV, $urandom, 32'd3);
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
         if (n == 11) bus.flush = 1'b1;
         if (n == 12) begin busy_at12 = bus.busy; bus.flush = 1'b0; end
      end
      n_tests += 3;
      if (busy_at12 !== 0) begin n_fail++; $display("FAIL flush_idle: got busy %b want 0", busy_at12); end
      if (dones !== 0) begin n_fail++; $display("FAIL flush_done: got %0d pulses want 0", dones); end
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
         n_fail++; $display("FAIL flush_hilo: got %h/%h want %h/%h", bus.hi, bus.lo, exp_hi, exp_lo);
      end
      bus.flush = 1'b1;
      issue(OP_MULT, 32'd9, 32'd9);
      bus.flush = 1'b0;
      n_tests++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_start: got busy %b want 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
      repeat (15) @(posedge clk);
      #1;
      bus.hilo_read = 1'b1;
      rst = 1'b0; #1;
      exp_hi = '0; exp_lo = '0;
      n_tests += 2;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         n_fail++; $display("FAIL midreset_hilo: got %h/%h want 0/0", bus.hi, bus.lo);
      end
      if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
         n_fail++; $display("FAIL midreset_busy_stall: got %b/%b want 0/0", bus.busy, bus.stall);
      end
      bus.hilo_read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_op("after_reset", OP_DIVU, 32'd100, 32'd7);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall_ignore();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
